// File: rtl/segled_scan_ctrl.sv
// Four-digit 7-segment scan scheduler with blanking gaps and frame-aligned display updates.
// Optional leading-zero blanking is enabled by defining SEGLED_LZB_EN.
module segled_scan_ctrl #(
    parameter int DWELL_CYC = 12500,
    parameter int BLANK_CYC = 500,
    parameter int CNT_W     = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        disp_en,
    input  logic        upd_valid,
    input  logic [15:0] upd_data,
    output logic        upd_ready,
    output logic [3:0]  digit_data,
    output logic [3:0]  seg_sel_n,
    output logic        frame_tick
);

    typedef enum logic [1:0] {S_OFF, S_BLANK, S_DRIVE} state_t;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  phase_q, phase_d;
    logic [15:0]       disp_buf_q, disp_buf_d;
    logic [15:0]       shadow_q;
    logic              pending_q, pending_d;
    logic              frame_end;
    logic              xfer, commit;
    logic [3:0]        sel_d, dat_d;
    logic [3:0]        sel_q, dat_q;
    logic              tick_q, rdy_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        frame_end = 1'b0;
        if (!disp_en) begin
            state_d = S_OFF;
            idx_d   = 2'd0;
            phase_d = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d = S_BLANK;
                    idx_d   = 2'd0;
                    phase_d = '0;
                end
                S_BLANK: begin
                    if (phase_q == BLANK_LAST) begin
                        state_d = S_DRIVE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + CNT_W'(1);
                    end
                end
                S_DRIVE: begin
                    if (phase_q == DWELL_LAST) begin
                        state_d   = S_BLANK;
                        phase_d   = '0;
                        idx_d     = idx_q + 2'd1;
                        frame_end = (idx_q == 2'd3);
                    end else begin
                        phase_d = phase_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_OFF;
                    idx_d   = 2'd0;
                    phase_d = '0;
                end
            endcase
        end
    end

    // A parked display has no frame boundary, so commit immediately while OFF.
    always_comb begin
        xfer       = upd_valid && !pending_q;
        commit     = pending_q && (frame_end || (state_q == S_OFF));
        disp_buf_d = commit ? shadow_q : disp_buf_q;
        pending_d  = pending_q;
        if (xfer) begin
            pending_d = 1'b1;
        end else if (commit) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        logic [3:0] supp;
        supp    = 4'b0000;
`ifdef SEGLED_LZB_EN
        supp[3] = (disp_buf_d[15:12] == 4'h0);
        supp[2] = supp[3] && (disp_buf_d[11:8] == 4'h0);
        supp[1] = supp[2] && (disp_buf_d[7:4] == 4'h0);
`endif
        sel_d = 4'hF;
        dat_d = disp_buf_d[{idx_d, 2'b00} +: 4];
        if (state_d == S_DRIVE) begin
            if (supp[idx_d]) begin
                dat_d = 4'hF;
            end else begin
                sel_d[idx_d] = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            idx_q      <= 2'd0;
            phase_q    <= '0;
            disp_buf_q <= 16'h0000;
            shadow_q   <= 16'h0000;
            pending_q  <= 1'b0;
            sel_q      <= 4'hF;
            dat_q      <= 4'h0;
            tick_q     <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            disp_buf_q <= disp_buf_d;
            if (xfer) begin
                shadow_q <= upd_data;
            end
            pending_q  <= pending_d;
            sel_q      <= sel_d;
            dat_q      <= dat_d;
            tick_q     <= frame_end;
            rdy_q      <= ~pending_d;
        end
    end

    assign seg_sel_n  = sel_q;
    assign digit_data = dat_q;
    assign frame_tick = tick_q;
    assign upd_ready  = rdy_q;

endmodule

// File: tb/tb_segled_scan_ctrl.sv
// Directed bench for segled_scan_ctrl with DWELL_CYC=4, BLANK_CYC=2 (24-cycle frame).
module tb_segled_scan_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        disp_en;
    logic        upd_valid;
    logic [15:0] upd_data;
    logic        upd_ready;
    logic [3:0]  digit_data;
    logic [3:0]  seg_sel_n;
    logic        frame_tick;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       en;
        logic [3:0] sel;
        logic [3:0] dat;
        logic       tick;
    } vec_t;

    vec_t tbl[49];

    segled_scan_ctrl #(.DWELL_CYC(4), .BLANK_CYC(2), .CNT_W(16)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .disp_en    (disp_en),
        .upd_valid  (upd_valid),
        .upd_data   (upd_data),
        .upd_ready  (upd_ready),
        .digit_data (digit_data),
        .seg_sel_n  (seg_sel_n),
        .frame_tick (frame_tick)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [3:0] lzb_sel[4];
    logic [3:0] lzb_dat[4];

    initial begin
        logic [3:0] one;
        int p, d;
        one = 4'b0001;
        // Two frames of the 16'h4321 scan pattern plus the first slot of the third.
        for (int k = 0; k < 49; k++) begin
            p = k % 24;
            d = p / 6;
            tbl[k].en   = 1'b1;
            tbl[k].sel  = ((p % 6) < 2) ? 4'hF : ~(one << d);
            tbl[k].dat  = 4'(d + 1);
            tbl[k].tick = (k == 24) || (k == 48);
        end
        lzb_sel[0] = 4'hE; lzb_dat[0] = 4'h0;
        lzb_sel[1] = 4'hD; lzb_dat[1] = 4'h7;
`ifdef SEGLED_LZB_EN
        lzb_sel[2] = 4'hF; lzb_dat[2] = 4'hF;
        lzb_sel[3] = 4'hF; lzb_dat[3] = 4'hF;
`else
        lzb_sel[2] = 4'hB; lzb_dat[2] = 4'h0;
        lzb_sel[3] = 4'h7; lzb_dat[3] = 4'h0;
`endif

        sys_rst = 1'b1; disp_en = 1'b0; upd_valid = 1'b0; upd_data = 16'h0;
        run(2);
        chk("rst_sel", 16'(seg_sel_n), 16'hF);
        chk("rst_dat", 16'(digit_data), 16'h0);
        chk("rst_rdy", 16'(upd_ready), 16'h1);
        chk("rst_tick", 16'(frame_tick), 16'h0);
        sys_rst = 1'b0;

        // Load 16'h4321 while OFF: immediate commit.
        upd_valid = 1'b1; upd_data = 16'h4321; step();
        chk("off_xfer_rdy", 16'(upd_ready), 16'h0);
        upd_valid = 1'b0; step();
        chk("off_commit_rdy", 16'(upd_ready), 16'h1);

        for (int k = 0; k < 49; k++) begin
            disp_en = tbl[k].en;
            step();
            chk($sformatf("scan_sel[%0d]", k), 16'(seg_sel_n), 16'(tbl[k].sel));
            chk($sformatf("scan_dat[%0d]", k), 16'(digit_data), 16'(tbl[k].dat));
            chk($sformatf("scan_tick[%0d]", k), 16'(frame_tick), 16'(tbl[k].tick));
        end

        // Mid-frame update during digit1 DRIVE; second word is held off.
        run(8);
        chk("mid_pre_sel", 16'(seg_sel_n), 16'hD);
        upd_valid = 1'b1; upd_data = 16'h1234; step();
        chk("mid_xfer_rdy", 16'(upd_ready), 16'h0);
        chk("mid_xfer_dat", 16'(digit_data), 16'h2);
        upd_data = 16'hABCD;
        for (int q = 10; q < 24; q++) begin
            step();
            chk($sformatf("held_rdy[%0d]", q), 16'(upd_ready), 16'h0);
            if (q == 14) chk("old_d2_dat", 16'(digit_data), 16'h3);
            if (q == 20) chk("old_d3_dat", 16'(digit_data), 16'h4);
        end
        step();
        chk("commit_tick", 16'(frame_tick), 16'h1);
        chk("commit_rdy", 16'(upd_ready), 16'h1);
        chk("commit_dat", 16'(digit_data), 16'h4);
        step();
        chk("second_xfer_rdy", 16'(upd_ready), 16'h0);
        upd_valid = 1'b0;
        step();
        chk("new_d0_sel", 16'(seg_sel_n), 16'hE);
        chk("new_d0_dat", 16'(digit_data), 16'h4);

        // Enable drop during digit2 DRIVE.
        run(12);
        chk("drop_pre_sel", 16'(seg_sel_n), 16'hB);
        chk("drop_pre_dat", 16'(digit_data), 16'h2);
        disp_en = 1'b0; step();
        chk("drop_sel", 16'(seg_sel_n), 16'hF);
        chk("drop_tick", 16'(frame_tick), 16'h0);
        step();
        chk("drop_commit_rdy", 16'(upd_ready), 16'h1);
        disp_en = 1'b1; step();
        chk("reen_blank0", 16'(seg_sel_n), 16'hF);
        step();
        chk("reen_blank1", 16'(seg_sel_n), 16'hF);
        step();
        chk("reen_sel", 16'(seg_sel_n), 16'hE);
        chk("reen_dat", 16'(digit_data), 16'hD);

        // Reset while digit2 is driven.
        run(12);
        chk("rst2_pre_sel", 16'(seg_sel_n), 16'hB);
        chk("rst2_pre_dat", 16'(digit_data), 16'hB);
        sys_rst = 1'b1; step();
        chk("rst2_sel", 16'(seg_sel_n), 16'hF);
        chk("rst2_dat", 16'(digit_data), 16'h0);
        chk("rst2_rdy", 16'(upd_ready), 16'h1);
        chk("rst2_tick", 16'(frame_tick), 16'h0);
        step();
        chk("rst2_sel_b", 16'(seg_sel_n), 16'hF);
        sys_rst = 1'b0; step();
        chk("post_rst_blank0", 16'(seg_sel_n), 16'hF);
        step();
        chk("post_rst_blank1", 16'(seg_sel_n), 16'hF);
        step();
        chk("post_rst_sel", 16'(seg_sel_n), 16'hE);
        chk("post_rst_dat", 16'(digit_data), 16'h0);

        // Update while OFF.
        disp_en = 1'b0; step();
        upd_valid = 1'b1; upd_data = 16'h0009; step();
        chk("off9_xfer_rdy", 16'(upd_ready), 16'h0);
        upd_valid = 1'b0; step();
        chk("off9_commit_rdy", 16'(upd_ready), 16'h1);
        disp_en = 1'b1; run(3);
        chk("off9_sel", 16'(seg_sel_n), 16'hE);
        chk("off9_dat", 16'(digit_data), 16'h9);

        // Leading-zero blanking on 16'h0070.
        disp_en = 1'b0; step();
        upd_valid = 1'b1; upd_data = 16'h0070; step();
        upd_valid = 1'b0; step();
        disp_en = 1'b1;
        for (int q = 0; q < 24; q++) begin
            step();
            if ((q % 6) == 2) begin
                chk($sformatf("lzb_sel[%0d]", q / 6), 16'(seg_sel_n), 16'(lzb_sel[q / 6]));
                chk($sformatf("lzb_dat[%0d]", q / 6), 16'(digit_data), 16'(lzb_dat[q / 6]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
